// File: rtl/pwm_dac_loader.sv
// Four-channel PWM DAC code loader: clamps written codes, spreads the 4-bit
// fraction into a 16-bit dither pattern, and commits all channels together on a sync edge.
module pwm_dac_loader #(
  parameter int PWM_FULL = 156,
  parameter int CODE_MAX = PWM_FULL * 16
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [11:0] wdata_i,
  input  logic        sync_i,
  output logic [23:0] dac_pwm_a_o,
  output logic [23:0] dac_pwm_b_o,
  output logic [23:0] dac_pwm_c_o,
  output logic [23:0] dac_pwm_d_o,
  output logic        busy_o,
  output logic        pending_o,
  output logic [1:0]  dbg_state_o
);

  localparam logic [11:0] LP_CODE_MAX = CODE_MAX[11:0];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SPREAD = 2'd2,
    ST_STORE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [11:0] r_code [4];
  logic [23:0] r_stage [4];
  logic [23:0] r_out [4];
  logic [3:0]  r_dirty;
  logic [1:0]  r_last;
  logic [1:0]  r_cur;
  logic [7:0]  r_int;
  logic [3:0]  r_frac;
  logic [3:0]  r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_pat;
  logic        r_pending;
  logic        r_sync_d;

  logic [11:0] w_wclamp;
  logic [1:0]  w_sel;
  logic [1:0]  w_idx;
  logic        w_found;
  logic [4:0]  w_sum;
  logic        w_busy;
  logic        w_edge;

  assign w_wclamp = (wdata_i > LP_CODE_MAX) ? LP_CODE_MAX : wdata_i;
  assign w_sum    = {1'b0, r_acc} + {1'b0, r_frac};
  assign w_busy   = (r_state != ST_IDLE);
  assign w_edge   = sync_i & ~r_sync_d;

  // Round-robin: first dirty channel strictly after the last one converted.
  always_comb begin
    w_sel   = r_last;
    w_idx   = r_last;
    w_found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && r_dirty[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|r_dirty) w_state_nxt = ST_LOAD;
      ST_LOAD:   w_state_nxt = ST_SPREAD;
      ST_SPREAD: if (r_cnt == 4'd15) w_state_nxt = ST_STORE;
      ST_STORE:  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_ff @(posedge adc_clk_i) begin
    if (!adc_rstn_i) begin
      for (int i = 0; i < 4; i++) begin
        r_code[i]  <= '0;
        r_stage[i] <= '0;
        r_out[i]   <= '0;
      end
      r_dirty   <= '0;
      r_last    <= 2'd3;
      r_cur     <= 2'd0;
      r_int     <= '0;
      r_frac    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_pat     <= '0;
      r_pending <= 1'b0;
      r_sync_d  <= 1'b0;
    end else begin
      r_sync_d <= sync_i;
      case (r_state)
        ST_LOAD: begin
          r_dirty[w_sel] <= 1'b0;
          r_cur          <= w_sel;
          r_last         <= w_sel;
          r_int          <= r_code[w_sel][11:4];
          r_frac         <= r_code[w_sel][3:0];
          r_acc          <= '0;
          r_cnt          <= '0;
          r_pat          <= '0;
        end
        ST_SPREAD: begin
          r_pat[r_cnt] <= w_sum[4];
          r_acc        <= w_sum[3:0];
          r_cnt        <= r_cnt + 4'd1;
        end
        ST_STORE: begin
          r_stage[r_cur] <= {r_int, r_pat};
          r_pending      <= 1'b1;
        end
        default: ;
      endcase
      // A write after the LOAD clear re-arms the channel, so a write during
      // its own conversion is picked up by a later reconversion.
      if (wr_i) begin
        r_code[addr_i]  <= w_wclamp;
        r_dirty[addr_i] <= 1'b1;
      end
      // STORE keeps busy high, so a commit never sees a half-updated set.
      if (w_edge && !w_busy && r_pending) begin
        for (int i = 0; i < 4; i++) r_out[i] <= r_stage[i];
        r_pending <= 1'b0;
      end
    end
  end

  assign dac_pwm_a_o = r_out[0];
  assign dac_pwm_b_o = r_out[1];
  assign dac_pwm_c_o = r_out[2];
  assign dac_pwm_d_o = r_out[3];
  assign busy_o      = w_busy;
  assign pending_o   = r_pending;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pwm_dac_loader.sv
// Directed bench for pwm_dac_loader: hand-computed codes/patterns, commit gating,
// reconversion on overwrite, reset mid-conversion and back-to-back throughput.
module tb_pwm_dac_loader;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [11:0] wdata = '0;
  logic        sync = 1'b0;
  logic [23:0] out_a, out_b, out_c, out_d;
  logic        busy, pending;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int busy_cycles = 0;
  logic busy_prev = 1'b0;

  always #5 clk = ~clk;

  pwm_dac_loader dut (
    .adc_clk_i   (clk),
    .adc_rstn_i  (rstn),
    .wr_i        (wr),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .sync_i      (sync),
    .dac_pwm_a_o (out_a),
    .dac_pwm_b_o (out_b),
    .dac_pwm_c_o (out_c),
    .dac_pwm_d_o (out_d),
    .busy_o      (busy),
    .pending_o   (pending),
    .dbg_state_o (dbg_state)
  );

  // Conversion activity observed on the falling edge, away from updates.
  always @(negedge clk) begin
    if (busy && !busy_prev) rises++;
    if (busy) busy_cycles++;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [11:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  // Engine done = idle on two consecutive cycles (inter-conversion gaps are one cycle).
  task automatic wait_quiet(input string tag);
    int idle_run = 0;
    int n = 0;
    while (idle_run < 2 && n < 400) begin
      tick(1);
      n++;
      if (!busy) idle_run++;
      else idle_run = 0;
    end
    check({tag, "_timeout"}, 32'(idle_run >= 2), 32'd1);
  endtask

  task automatic check_outs(input string tag, input logic [23:0] a, input logic [23:0] b,
                            input logic [23:0] c, input logic [23:0] d);
    check({tag, "_a"}, 32'(out_a), 32'(a));
    check({tag, "_b"}, 32'(out_b), 32'(b));
    check({tag, "_c"}, 32'(out_c), 32'(c));
    check({tag, "_d"}, 32'(out_d), 32'(d));
  endtask

  int r0, b0;

  initial begin
    // Reset and release
    tick(3);
    rstn = 1'b1;
    tick(1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check_outs("rst", 24'h0, 24'h0, 24'h0, 24'h0);

    // A=0x085: frac 5 puts carries at steps 3,6,9,12,15 -> 0x9248; 19-cycle latency
    write(2'd0, 12'h085);
    check("a_busy_after_wr", 32'(busy), 32'd0);
    tick(18);
    check("a_store_busy", 32'(busy), 32'd1);
    check("a_store_pending", 32'(pending), 32'd0);
    tick(1);
    check("a_staged_pending", 32'(pending), 32'd1);
    check("a_staged_busy", 32'(busy), 32'd0);
    check_outs("a_precommit", 24'h0, 24'h0, 24'h0, 24'h0);
    sync_pulse();
    check_outs("a_commit", 24'h08_9248, 24'h0, 24'h0, 24'h0);
    check("a_commit_pending", 32'(pending), 32'd0);

    // B, C, D with a commit attempt while busy; D clamps 0xFFF -> 0x9C0
    write(2'd1, 12'h0A8);
    write(2'd2, 12'h01F);
    write(2'd3, 12'hFFF);
    tick(5);
    check("bcd_busy", 32'(busy), 32'd1);
    sync_pulse();
    check_outs("bcd_deferred", 24'h08_9248, 24'h0, 24'h0, 24'h0);
    wait_quiet("bcd");
    check("bcd_pending", 32'(pending), 32'd1);
    check_outs("bcd_still_old", 24'h08_9248, 24'h0, 24'h0, 24'h0);
    sync_pulse();
    check_outs("bcd_commit", 24'h08_9248, 24'h0A_AAAA, 24'h01_FFFE, 24'h9C_0000);

    // Sync edge with nothing pending leaves outputs alone
    tick(2);
    sync_pulse();
    check_outs("nopend", 24'h08_9248, 24'h0A_AAAA, 24'h01_FFFE, 24'h9C_0000);

    // Sync held high counts as one edge only
    tick(2);
    sync = 1'b1;
    tick(1);
    write(2'd0, 12'h030);
    wait_quiet("hold");
    tick(3);
    check("hold_pending", 32'(pending), 32'd1);
    check("hold_a", 32'(out_a), 32'h08_9248);
    sync = 1'b0;
    tick(1);
    sync_pulse();
    check("hold_commit_a", 32'(out_a), 32'h03_0000);

    // Overwrite A during its own SPREAD -> two conversions, final code wins
    r0 = rises;
    write(2'd0, 12'h010);
    tick(3);
    check("ow_in_spread", 32'(dbg_state), 32'd2);
    write(2'd0, 12'h020);
    wait_quiet("ow");
    check("ow_conversions", 32'(rises - r0), 32'd2);
    sync_pulse();
    check_outs("ow_commit", 24'h02_0000, 24'h0A_AAAA, 24'h01_FFFE, 24'h9C_0000);

    // Back-to-back writes to all four: 4 conversions x 18 busy cycles
    tick(2);
    r0 = rises;
    b0 = busy_cycles;
    write(2'd0, 12'h011);
    write(2'd1, 12'h022);
    write(2'd2, 12'h033);
    write(2'd3, 12'h044);
    wait_quiet("b2b");
    check("b2b_busy_cycles", 32'(busy_cycles - b0), 32'd72);
    check("b2b_conversions", 32'(rises - r0), 32'd4);
    sync_pulse();
    check_outs("b2b_commit", 24'h01_8000, 24'h02_8080, 24'h03_8420, 24'h04_8888);

    // Reset during SPREAD abandons everything
    write(2'd1, 12'h0FF);
    tick(4);
    check("rs_in_spread", 32'(dbg_state), 32'd2);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(1);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_pending", 32'(pending), 32'd0);
    check_outs("rs", 24'h0, 24'h0, 24'h0, 24'h0);
    tick(25);
    check("rs_later_pending", 32'(pending), 32'd0);
    sync_pulse();
    check_outs("rs_sync", 24'h0, 24'h0, 24'h0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
